// File: rtl/parser_pkg.sv
// -----------------------------------------------------------------------------
// parser_pkg
//   Shared types and defaults for the AV1 bitstream parser chain.
//   - PARSER_DATA_WIDTH : default input word width (bits, multiple of 8)
//   - OBU_SIZE_W        : width of the decoded leb128 obu_size
//   - obu_type_e        : AV1 OBU type codes used by downstream parsers
//   - obu_header_t      : decoded OBU header handed to the next parser
// -----------------------------------------------------------------------------
package parser_pkg;

   localparam int PARSER_DATA_WIDTH = 32;
   localparam int OBU_SIZE_W        = 32;

   typedef enum logic [3:0] {
      SEQUENCE_HEADER    = 4'd1,
      TEMPORAL_DELIMITER = 4'd2,
      FRAME_HEADER       = 4'd3,
      TILE_GROUP         = 4'd4,
      METADATA           = 4'd5,
      FRAME              = 4'd6,
      PADDING            = 4'd15
   } obu_type_e;

   typedef struct packed {
      logic [3:0]            obu_type;
      logic                  extension_flag;
      logic                  has_size_field;
      logic [2:0]            temporal_id;
      logic [1:0]            spatial_id;
      logic [OBU_SIZE_W-1:0] obu_size;
   } obu_header_t;

endpackage

// File: rtl/obu_header_parser_leb128_decoder.sv
// -----------------------------------------------------------------------------
// leb128_decoder
//   Byte-serial unsigned leb128 accumulator. Each enabled byte ORs its 7-bit
//   payload into the value at bit position 7*i, where i counts accepted bytes
//   since the last clear.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     clear      : restart accumulation (value and byte count to zero)
//     byte_en    : byte_in is consumed this cycle
//     byte_in    : current leb128 byte
//     value      : accumulated value (registered)
//     last       : current byte terminates the number (continuation bit = 0)
//     overflow   : current byte places a set bit at or above OBU_SIZE_W
//     too_long   : current byte is the 8th and still has its continuation bit
//   last/overflow/too_long are combinational and qualified by byte_en.
// -----------------------------------------------------------------------------
module leb128_decoder #(
   parameter int OBU_SIZE_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  byte_en,
   input  logic [7:0]            byte_in,
   output logic [OBU_SIZE_W-1:0] value,
   output logic                  last,
   output logic                  overflow,
   output logic                  too_long
);

   logic [2:0]            cnt_q, cnt_d;
   logic [OBU_SIZE_W-1:0] value_q, value_d;
   logic [6:0]            bit_ovf;

   // Per payload bit: does it land outside the result for the current byte?
   genvar gi;
   for (gi = 0; gi < 7; gi++) begin : g_payload_bit
      logic [6:0] bit_pos;
      assign bit_pos     = 7'(cnt_q) * 7'd7 + 7'(gi);
      assign bit_ovf[gi] = byte_in[gi] && (int'(bit_pos) >= OBU_SIZE_W);
   end

   always_comb begin
      value_d = value_q;
      cnt_d   = cnt_q;
      if (clear) begin
         value_d = '0;
         cnt_d   = '0;
      end else if (byte_en) begin
         // Payload bits shifted past the top are dropped; overflow flags them.
         value_d = value_q | (OBU_SIZE_W'(byte_in[6:0]) << (7 * cnt_q));
         cnt_d   = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
         cnt_q   <= '0;
      end else begin
         value_q <= value_d;
         cnt_q   <= cnt_d;
      end
   end

   assign value    = value_q;
   assign last     = byte_en && !byte_in[7];
   assign overflow = byte_en && (|bit_ovf);
   assign too_long = byte_en && byte_in[7] && (cnt_q == 3'd7);

endmodule

// File: rtl/obu_header_parser.sv
// -----------------------------------------------------------------------------
// obu_header_parser
//   Byte-serial AV1 OBU header parser. Starting at byte_offset inside the
//   current word, consumes the header byte, the optional extension byte and
//   the optional leb128 obu_size, one byte per cycle while data_valid is high.
//   Reports the decoded header, a forbidden-bit / leb128 error, and how much
//   of the current word was used so the next parser can continue from there.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     data_in      : bitstream word, byte 0 in the MSBs
//     data_valid   : data_in is valid this cycle
//     start        : begin a parse (only looked at in IDLE)
//     byte_offset  : bytes of data_in already used upstream, taken with start
//     pop          : combinational, current word fully consumed this cycle
//     done         : one-cycle result pulse
//     error        : parse failed (held until next start)
//     hdr          : decoded header (held until next start)
//     pad/pad_len  : current word partially consumed / bits consumed
// -----------------------------------------------------------------------------
module obu_header_parser
   import parser_pkg::*;
#(
   parameter int  PARSER_DATA_WIDTH = parser_pkg::PARSER_DATA_WIDTH,
   parameter int  OBU_SIZE_W        = parser_pkg::OBU_SIZE_W,
   localparam int BYTES             = PARSER_DATA_WIDTH / 8,
   localparam int OFF_W             = (BYTES > 1) ? $clog2(BYTES) : 1,
   localparam int PL_W              = $clog2(PARSER_DATA_WIDTH)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [PARSER_DATA_WIDTH-1:0] data_in,
   input  logic                         data_valid,
   input  logic                         start,
   input  logic [OFF_W-1:0]             byte_offset,
   output logic                         pop,
   output logic                         done,
   output logic                         error,
   output obu_header_t                  hdr,
   output logic                         pad,
   output logic [PL_W-1:0]              pad_len
);

   localparam int HDR_SIZE_W = parser_pkg::OBU_SIZE_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_EXT,
      S_SIZE,
      S_DONE,
      S_ERR_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [OFF_W-1:0] idx_q, idx_d;
   logic [3:0]       type_q, type_d;
   logic             ext_q, ext_d;
   logic             hs_q, hs_d;
   logic [2:0]       tid_q, tid_d;
   logic [1:0]       sid_q, sid_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             pad_q, pad_d;
   logic [PL_W-1:0]  pad_len_q, pad_len_d;

   logic [7:0]       word_bytes [BYTES];
   logic [7:0]       cur_byte;
   logic             busy;
   logic             consuming;
   logic             last_byte;
   logic             terminal_d;

   logic                  leb_clear;
   logic                  leb_en;
   logic [OBU_SIZE_W-1:0] leb_value;
   logic                  leb_last;
   logic                  leb_overflow;
   logic                  leb_too_long;

   // Split the word into bytes, byte 0 being the most significant.
   genvar gi;
   for (gi = 0; gi < BYTES; gi++) begin : g_word_byte
      assign word_bytes[gi] = data_in[PARSER_DATA_WIDTH-1-8*gi -: 8];
   end

   assign cur_byte  = word_bytes[idx_q];
   assign busy      = (state_q == S_HDR) || (state_q == S_EXT) || (state_q == S_SIZE);
   // A reset cycle never consumes, so upstream never sees a pop it must undo.
   assign consuming = busy && data_valid && !rst;
   assign last_byte = (idx_q == OFF_W'(BYTES - 1));
   assign pop       = consuming && last_byte;

   assign leb_clear = (state_q == S_IDLE) && start;
   assign leb_en    = consuming && (state_q == S_SIZE);

   leb128_decoder #(
      .OBU_SIZE_W (OBU_SIZE_W)
   ) u_leb128 (
      .clk      (clk),
      .rst      (rst),
      .clear    (leb_clear),
      .byte_en  (leb_en),
      .byte_in  (cur_byte),
      .value    (leb_value),
      .last     (leb_last),
      .overflow (leb_overflow),
      .too_long (leb_too_long)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      type_d    = type_q;
      ext_d     = ext_q;
      hs_d      = hs_q;
      tid_d     = tid_q;
      sid_d     = sid_q;
      done_d    = 1'b0;
      error_d   = error_q;
      pad_d     = pad_q;
      pad_len_d = pad_len_q;

      if (consuming) begin
         idx_d = last_byte ? '0 : idx_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_HDR;
               idx_d     = (BYTES > 1) ? byte_offset : '0;
               type_d    = '0;
               ext_d     = 1'b0;
               hs_d      = 1'b0;
               tid_d     = '0;
               sid_d     = '0;
               error_d   = 1'b0;
               pad_d     = 1'b0;
               pad_len_d = '0;
            end
         end
         S_HDR: begin
            if (data_valid) begin
               type_d = cur_byte[6:3];
               ext_d  = cur_byte[2];
               hs_d   = cur_byte[1];
               if (cur_byte[7]) begin
                  state_d = S_ERR_DONE;
               end else if (cur_byte[2]) begin
                  state_d = S_EXT;
               end else if (cur_byte[1]) begin
                  state_d = S_SIZE;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_EXT: begin
            if (data_valid) begin
               tid_d   = cur_byte[7:5];
               sid_d   = cur_byte[4:3];
               state_d = hs_q ? S_SIZE : S_DONE;
            end
         end
         S_SIZE: begin
            if (data_valid) begin
               if (leb_overflow || leb_too_long) begin
                  state_d = S_ERR_DONE;
               end else if (leb_last) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE, S_ERR_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Result outputs are loaded on the edge that enters a terminal state,
      // using the post-consumption byte index.
      terminal_d = (state_d == S_DONE) || (state_d == S_ERR_DONE);
      if (busy && terminal_d) begin
         done_d    = 1'b1;
         error_d   = (state_d == S_ERR_DONE);
         pad_d     = (idx_d != '0);
         pad_len_d = PL_W'({idx_d, 3'b000});
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         type_q    <= '0;
         ext_q     <= 1'b0;
         hs_q      <= 1'b0;
         tid_q     <= '0;
         sid_q     <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         pad_q     <= 1'b0;
         pad_len_q <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         type_q    <= type_d;
         ext_q     <= ext_d;
         hs_q      <= hs_d;
         tid_q     <= tid_d;
         sid_q     <= sid_d;
         done_q    <= done_d;
         error_q   <= error_d;
         pad_q     <= pad_d;
         pad_len_q <= pad_len_d;
      end
   end

   // obu_size lives in the leb128 accumulator; it stays zero without a size field.
   always_comb begin
      hdr                = '0;
      hdr.obu_type       = type_q;
      hdr.extension_flag = ext_q;
      hdr.has_size_field = hs_q;
      hdr.temporal_id    = tid_q;
      hdr.spatial_id     = sid_q;
      hdr.obu_size       = HDR_SIZE_W'(leb_value);
   end

   assign done    = done_q;
   assign error   = error_q;
   assign pad     = pad_q;
   assign pad_len = pad_len_q;

endmodule

// File: tb/tb_obu_header_parser.sv
module tb_obu_header_parser;
   import parser_pkg::*;

   localparam int W  = 32;
   localparam int NB = W / 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [W-1:0] data_in;
   logic        data_valid;
   logic        start;
   logic [1:0]  byte_offset;
   logic        pop;
   logic        done;
   logic        error;
   obu_header_t hdr;
   logic        pad;
   logic [4:0]  pad_len;

   int checks = 0;
   int errors = 0;

   // Header bytes starting at the parse offset, and the flattened word stream.
   logic [7:0] hb[$];
   logic [7:0] flat[$];

   // Reference results.
   int     exp_err, exp_n, exp_forb, exp_type, exp_ext, exp_hs, exp_tid, exp_sid;
   longint exp_size;

   always #5 clk = ~clk;

   obu_header_parser #(
      .PARSER_DATA_WIDTH (W),
      .OBU_SIZE_W        (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .data_in     (data_in),
      .data_valid  (data_valid),
      .start       (start),
      .byte_offset (byte_offset),
      .pop         (pop),
      .done        (done),
      .error       (error),
      .hdr         (hdr),
      .pad         (pad),
      .pad_len     (pad_len)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [W-1:0] word_at(input int w);
      logic [W-1:0] r;
      r = '0;
      for (int k = 0; k < NB; k++) begin
         if (w * NB + k < flat.size()) r[W-1-8*k -: 8] = flat[w*NB+k];
      end
      return r;
   endfunction

   // Reference: walk the byte list as a number-level leb128 decode.
   task automatic model();
      logic [7:0] b;
      longint     acc;
      int         p;
      b        = hb[0];
      exp_forb = int'(b[7]);
      exp_type = int'(b[6:3]);
      exp_ext  = int'(b[2]);
      exp_hs   = int'(b[1]);
      exp_tid  = 0;
      exp_sid  = 0;
      exp_size = 0;
      exp_err  = 0;
      exp_n    = 1;
      if (exp_forb != 0) begin
         exp_err = 1;
      end else begin
         p = 1;
         if (exp_ext != 0) begin
            exp_tid = int'(hb[1]) / 32;
            exp_sid = (int'(hb[1]) / 8) % 4;
            p = 2;
         end
         exp_n = p;
         if (exp_hs != 0) begin
            acc = 0;
            for (int i = 0; i < 8; i++) begin
               b = hb[p+i];
               acc = acc + (longint'(b[6:0]) << (7 * i));
               exp_n = p + i + 1;
               if (acc >= 64'h1_0000_0000) begin
                  exp_err = 1;
                  break;
               end
               if (b < 8'd128) begin
                  exp_size = acc;
                  break;
               end
               if (i == 7) exp_err = 1;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      start = 1'b0;
      data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".done"}, done, 0);
      check({tag, ".error"}, error, 0);
      check({tag, ".pad"}, pad, 0);
      check({tag, ".pad_len"}, pad_len, 0);
      check({tag, ".hdr"}, 64'(hdr), 0);
      check({tag, ".pop"}, pop, 0);
   endtask

   // Entered and left at posedge+1 with the DUT in IDLE.
   task automatic run_txn(input int off, input int stall_pct, input string name);
      int   cyc, pops, stalls, widx, rem;
      logic pop_seen;
      bit   got;
      model();
      flat.delete();
      for (int i = 0; i < off; i++) flat.push_back(8'($urandom));
      foreach (hb[i]) flat.push_back(hb[i]);
      while (flat.size() % NB != 0) flat.push_back(8'($urandom));
      for (int i = 0; i < NB; i++) flat.push_back(8'($urandom));
      widx = 0; pops = 0; stalls = 0; got = 0;
      start       = 1'b1;
      byte_offset = 2'(off);
      data_in     = word_at(0);
      data_valid  = ($urandom_range(0, 99) >= stall_pct);
      for (cyc = 0; cyc < 300; cyc++) begin
         @(negedge clk);
         if (cyc > 0 && done) begin
            got = 1;
            break;
         end
         pop_seen = pop;
         if (pop) pops++;
         if (cyc >= 1 && !data_valid) stalls++;
         @(posedge clk);
         #1;
         start       = ($urandom_range(0, 3) == 0);
         byte_offset = 2'($urandom);
         if (pop_seen) widx++;
         data_in     = word_at(widx);
         data_valid  = ($urandom_range(0, 99) >= stall_pct);
      end
      if (!got) begin
         check({name, ".timeout"}, 0, 1);
         do_reset();
         return;
      end
      rem = (off + exp_n) % NB;
      check({name, ".done_cycle"}, cyc, exp_n + 1 + stalls);
      check({name, ".error"}, error, exp_err);
      check({name, ".pops"}, pops, (off + exp_n) / NB);
      check({name, ".pad_len"}, pad_len, 8 * rem);
      check({name, ".pad"}, pad, rem != 0);
      if (exp_forb == 0) begin
         check({name, ".obu_type"}, hdr.obu_type, exp_type);
         check({name, ".ext_flag"}, hdr.extension_flag, exp_ext);
         check({name, ".has_size"}, hdr.has_size_field, exp_hs);
         check({name, ".temporal_id"}, hdr.temporal_id, exp_tid);
         check({name, ".spatial_id"}, hdr.spatial_id, exp_sid);
      end
      if (exp_err == 0) check({name, ".obu_size"}, hdr.obu_size, exp_size);
      $display("txn %s off=%0d bytes=%0d stalls=%0d type=%0d err=%0d size=%0d pad_len=%0d",
               name, off, exp_n, stalls, exp_type, exp_err, exp_size, 8 * rem);
      @(posedge clk);
      #1;
      start      = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      check({name, ".done_pulse"}, done, 0);
      @(posedge clk);
      #1;
   endtask

   task automatic gen_random();
      logic [7:0] b;
      int         len, pay;
      hb.delete();
      b = 8'($urandom);
      if ($urandom_range(0, 9) != 0) b[7] = 1'b0;
      hb.push_back(b);
      if (b[2]) hb.push_back(8'($urandom));
      if (b[1]) begin
         len = $urandom_range(1, 9);
         for (int j = 0; j < len; j++) begin
            pay = $urandom_range(0, 127);
            if (j >= 4 && $urandom_range(0, 2) != 0) pay = (j == 4) ? (pay % 16) : 0;
            hb.push_back(8'((j < len - 1) ? (128 + pay) : pay));
         end
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      start       = 1'b0;
      data_valid  = 1'b0;
      data_in     = '0;
      byte_offset = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset_held");
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk);
      #1;

      // Header plus one size byte.
      hb = '{8'h0A, 8'h0B};
      run_txn(0, 0, "s1");
      check("s1.type_const", hdr.obu_type, 1);
      check("s1.size_const", hdr.obu_size, 11);

      // Extension, no size field.
      hb = '{8'h34, 8'h48};
      run_txn(0, 0, "s2");
      check("s2.type_const", hdr.obu_type, 6);
      check("s2.tid_const", hdr.temporal_id, 2);
      check("s2.sid_const", hdr.spatial_id, 1);

      // Crossing a word boundary.
      hb = '{8'h12, 8'hE5, 8'h8E, 8'h26};
      run_txn(3, 0, "s3");
      check("s3.size_const", hdr.obu_size, 624485);
      check("s3.type_const", hdr.obu_type, 2);

      // Forbidden bit.
      hb = '{8'h8A};
      run_txn(0, 0, "s4");
      check("s4.error_const", error, 1);

      // Over-long leb128.
      hb = '{8'h0A, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
      run_txn(0, 0, "s5");
      check("s5.error_const", error, 1);

      // Stalls during parsing.
      hb = '{8'h0A, 8'h8B, 8'h8C, 8'h01};
      run_txn(1, 40, "s6_stall");

      // Reset in SIZE on the word's last byte: no pop, everything cleared.
      flat.delete();
      start       = 1'b1;
      byte_offset = 2'd0;
      data_in     = 32'h0A80_8080;
      data_valid  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      @(negedge clk);
      check("s6_rst.pop_in_reset", pop, 0);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      data_valid = 1'b0;
      @(negedge clk);
      check_idle_outputs("s6_rst");
      @(posedge clk);
      #1;
      hb = '{8'h0A, 8'h0B};
      run_txn(0, 0, "s6_after_rst");
      check("s6_after_rst.size_const", hdr.obu_size, 11);

      for (int t = 0; t < 150; t++) begin
         gen_random();
         run_txn($urandom_range(0, NB - 1), $urandom_range(0, 30), $sformatf("rnd%0d", t));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/obu_header_parser.md
# obu_header_parser

Byte-serial AV1 OBU header parser with a configurable word width. It sits at the front of the parser chain, ahead of `sequence_header_parser` and the other per-OBU parsers. It consumes the MSB-first word stream at any byte offset, decodes the OBU header, the optional extension byte and the leb128 `obu_size`, and reports forbidden-bit and leb128 violations. It hands the partially consumed word to the next parser through `pad`/`pad_len`.

## Interface
- `PARSER_DATA_WIDTH`, default 32: input word width. Must be a multiple of 8, range 8..64.
- `OBU_SIZE_W`, default 32: width of the decoded `obu_size`.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `data_in` input, `PARSER_DATA_WIDTH` bits: current bitstream word. Byte 0 is `data_in[W-1 -: 8]`.
- `data_valid` input, 1 bit: `data_in` holds a valid word.
- `start` input, 1 bit: begin parsing. Sampled only in IDLE.
- `byte_offset` input, `$clog2(W/8)` bits: bytes of `data_in` already consumed upstream. Sampled with `start`. Tied to 0 when W=8.
- `pop` output, 1 bit: current word fully consumed. Upstream advances on this edge.
- `done` output, 1 bit: one-cycle pulse; `hdr`, `error`, `pad`, `pad_len` are valid.
- `error` output, 1 bit: parse failed. Valid with `done`, held until the next `start`.
- `hdr` output, `obu_header_t`: decoded header. Held until the next `start`.
- `pad` output, 1 bit: current word is partially consumed (`pad_len != 0`).
- `pad_len` output, `$clog2(W)` bits: bits of the current word consumed, always a multiple of 8.

## Operation
- **States:** IDLE → HDR → [EXT] → [SIZE] → DONE → IDLE. ERR_DONE is an alternative terminal state that also returns to IDLE.
- **IDLE:** on `start`, latch `idx = byte_offset`, clear `hdr` and `error`, go to HDR.
- **Byte consumption:** in HDR, EXT and SIZE, one byte is consumed per cycle, only when `data_valid=1`.
  - Each consumption increments `idx`.
  - When `idx == W/8-1`, `pop=1` that cycle and `idx` wraps to 0.
  - `pop` is combinational: (consuming) && (last byte).
- **HDR:** decode `forbidden` from b[7], `obu_type` from b[6:3], `extension_flag` from b[2], `has_size_field` from b[1]. b[0] is ignored.
  - If `forbidden=1`, go to ERR_DONE.
  - Otherwise go to EXT if `extension_flag`, else SIZE if `has_size_field`, else DONE.
- **EXT:** `temporal_id` = b[7:5], `spatial_id` = b[4:3]. Then go to SIZE if `has_size_field`, else DONE.
- **SIZE (leb128):** `obu_size |= b[6:0] << 7*i` for i = 0..7.
  - b[7]=0: go to DONE.
  - b[7]=1 on i=7: go to ERR_DONE (more than 8 bytes).
  - Any bit landing at or above `OBU_SIZE_W`: go to ERR_DONE (overflow).
- **No size field:** `obu_size = 0`.
- **DONE / ERR_DONE:** `done=1` for one cycle. ERR_DONE additionally sets `error=1`. `pad_len = 8*idx`, `pad = (idx != 0)`.
- **Ignored inputs:** `start` outside IDLE is ignored. `data_in` is ignored while `data_valid=0`, and no state advances.
- **Mid-operation reset:** `rst` returns to IDLE with no `pop`. The partial header is discarded.

## Timing
- **Reset values:** `pop`, `done`, `error`, `pad` = 0; `pad_len` = 0; `hdr` = all zero; state = IDLE.
- **Latency:** start at cycle 0, first byte consumed at cycle 1. With `N` bytes and no stalls, `done` is at cycle `N+1`. Each `data_valid=0` cycle adds one cycle.
- **Pop handshake:** upstream presents the next word, or drops `data_valid`, in the cycle after `pop`. Back-to-back pops are legal only when W=8.
- **Output timing:** `done`, `pad`, `pad_len` are registered. `pop` is not registered.
- **Word-boundary exit:** if the final byte is the word's last byte, `pop` fires in that same cycle and `done` follows with `pad=0`, `pad_len=0`.

## Structure
- **Package `parser_pkg`** holds:
  - `PARSER_DATA_WIDTH` default;
  - `obu_header_t` {`obu_type[3:0]`, `extension_flag`, `has_size_field`, `temporal_id[2:0]`, `spatial_id[1:0]`, `obu_size[OBU_SIZE_W-1:0]`};
  - `obu_type_e` (SEQUENCE_HEADER=1, TEMPORAL_DELIMITER=2, FRAME_HEADER=3, TILE_GROUP=4, METADATA=5, FRAME=6, PADDING=15).
- **Local to this module:** the FSM state enum.
- **Sub-module `leb128_decoder`:** byte-serial accumulator with clear, byte-enable, `last`, `overflow` and `too_long` outputs, parametrised on `OBU_SIZE_W`.

## Test plan
All scenarios use W=32.
1. **Header plus one size byte:** offset 0, `data_in=0x0A0B_0000`, valid → `hdr.obu_type=1`, `has_size_field=1`, `obu_size=11`. `done` at cycle 3, `pad=1`, `pad_len=16`, no `pop`.
2. **Extension, no size:** offset 0, `data_in=0x3448_0000` → `obu_type=6`, `temporal_id=2`, `spatial_id=1`, `obu_size=0`. `done` at cycle 3, `pad_len=16`.
3. **Crossing a word:** offset 3, word0 byte3 = 0x12, word1 = 0xE58E_26FF → `pop` in cycle 1. Result `obu_type=2`, `obu_size=624485`, `pad_len=24`, `error=0`.
4. **Forbidden bit:** header byte 0x8A → `done` and `error=1` at cycle 2. `obu_size=0`, `pad_len=8`.
5. **Over-long leb128:** header 0x0A followed by eight bytes of 0x80 → `error=1` after the 8th size byte, with exactly two pops on the way.
6. **Stall and reset:** three `data_valid=0` cycles during SIZE → `done` is 3 cycles later. Assert `rst` during SIZE → IDLE, all outputs 0; the next `start` parses scenario 1 correctly.
